// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU scheduler: opcode values and FSM state encoding.
package alu_share_pkg;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_MUL     = 4'd2;
  localparam logic [3:0] OP_AND     = 4'd3;
  localparam logic [3:0] OP_OR      = 4'd4;
  localparam logic [3:0] OP_XOR     = 4'd5;
  localparam logic [3:0] OP_XNOR    = 4'd6;
  localparam logic [3:0] OP_SHL     = 4'd7;
  localparam logic [3:0] OP_SHR     = 4'd8;
  localparam logic [3:0] OP_ASHR    = 4'd9;
  localparam logic [3:0] OP_DIV     = 4'd10;
  localparam logic [3:0] OP_MOD     = 4'd11;
  localparam logic [3:0] OP_REDAND  = 4'd12;
  localparam logic [3:0] OP_REDOR   = 4'd13;
  localparam logic [3:0] OP_REDXOR  = 4'd14;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DIV, ST_RESP} state_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_share_div.sv
// Iterative restoring divider: one quotient bit per cycle, done pulses WIDTH cycles after start.
module alu_share_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_r, r_r, d_r;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic [WIDTH:0]   rem_shift, diff;
  logic             step_ok;
  logic [WIDTH-1:0] step_q, step_r;

  // The final step is presented combinationally so done lines up with the last cycle.
  always_comb begin
    rem_shift = {r_r, q_r[WIDTH-1]};
    diff      = rem_shift - {1'b0, d_r};
    step_ok   = ~diff[WIDTH];
    step_r    = step_ok ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    step_q    = {q_r[WIDTH-2:0], step_ok};
  end

  assign done = busy && (cnt == CW'(1));
  assign quot = step_q;
  assign rem  = step_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= '0;
      r_r  <= '0;
      d_r  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      q_r  <= a;
      r_r  <= '0;
      d_r  <= b;
      cnt  <= CW'(WIDTH);
      busy <= 1'b1;
    end else if (busy) begin
      q_r <= step_q;
      r_r <= step_r;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one integer ALU (plus iterative divider) among N requesters.
module alu_share_sched
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 2,
  parameter int IDW   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [4*N-1:0]       req_op,
  input  logic [WIDTH*N-1:0]   req_a,
  input  logic [WIDTH*N-1:0]   req_b,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_err,
  input  logic                 rsp_ready
);

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, rr_nxt, win, id_q;
  logic             found, accept, div_start, div_done;
  logic [3:0]       sel_op, op_q;
  logic [WIDTH-1:0] sel_a, sel_b, a_q, b_q;
  logic [WIDTH-1:0] alu_res, rsp_data_q, div_quot, div_rem;
  logic             alu_err, rsp_err_q;

  // Pass 0 searches from rr_ptr upward, pass 1 wraps to the indices below it.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_valid[i] && (p == 1 || i >= int'(rr_ptr))) begin
          found  = 1'b1;
          win    = IDW'(i);
          sel_op = req_op[4*i +: 4];
          sel_a  = req_a[WIDTH*i +: WIDTH];
          sel_b  = req_b[WIDTH*i +: WIDTH];
        end
      end
    end
  end

  assign accept    = (state == ST_IDLE) && found && !rst;
  assign div_start = accept && is_div_op(sel_op);
  assign rr_nxt    = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) req_ready[i] = accept && (win == IDW'(i));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_div_op(sel_op) ? ST_DIV : ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_DIV:  if (div_done) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Shift amounts use all of b, so oversize shifts naturally yield zero or sign fill.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD:     alu_res = a_q + b_q;
      OP_SUB:     alu_res = a_q - b_q;
      OP_MUL:     alu_res = a_q * b_q;
      OP_AND:     alu_res = a_q & b_q;
      OP_OR:      alu_res = a_q | b_q;
      OP_XOR:     alu_res = a_q ^ b_q;
      OP_XNOR:    alu_res = ~(a_q ^ b_q);
      OP_SHL:     alu_res = a_q << b_q;
      OP_SHR:     alu_res = a_q >> b_q;
      OP_ASHR:    alu_res = $unsigned($signed(a_q) >>> b_q);
      OP_REDAND:  alu_res = WIDTH'(&a_q);
      OP_REDOR:   alu_res = WIDTH'(|a_q);
      OP_REDXOR:  alu_res = WIDTH'(^a_q);
      OP_ILLEGAL: alu_err = 1'b1;
      default:    alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= rr_nxt;
        id_q   <= win;
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
      end
      if (state == ST_EXEC) begin
        rsp_data_q <= alu_res;
        rsp_err_q  <= alu_err;
      end
      if (state == ST_DIV && div_done) begin
        rsp_data_q <= (op_q == OP_DIV) ? div_quot : div_rem;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  alu_share_div #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (sel_a),
    .b     (sel_b),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem)
  );

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: arithmetic reference model, round-robin grant model, decoupled response monitor.
module tb_alu_share_sched;
  import alu_share_pkg::*;

  localparam int WIDTH = 8;
  localparam int N     = 2;
  localparam int IDW   = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [4*N-1:0]       req_op;
  logic [WIDTH*N-1:0]   req_a, req_b;
  logic [N-1:0]         req_ready;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [WIDTH-1:0]     rsp_data;
  logic                 rsp_err;
  logic                 rsp_ready;

  always #5 clk = ~clk;

  alu_share_sched #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready)
  );

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    logic             err;
    int               lat;
    int               tacc;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   nChecks = 0, nPass = 0, cyc = 0;
  int   mptr = 0, inflight = 0, rdyMode = 1;
  int   waitCnt[N];
  bit   acc[N];
  bit   held, stableOk;
  logic [IDW+WIDTH:0] heldVal;
  logic [3:0]         rop;
  logic [WIDTH-1:0]   ra, rb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input bit ok, input string name, input longint act, input longint exp);
    nChecks++;
    if (ok) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Result from the arithmetic definition of each opcode, returned as {err, data}.
  function automatic logic [WIDTH:0] refModel(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    longint unsigned m, ua, ub, r;
    longint          sa, q, p2;
    int              ones;
    logic            err;
    m = longint'(1) << WIDTH;
    ua = a; ub = b; r = 0; err = 1'b0; ones = 0;
    case (op)
      4'd0:  r = (ua + ub) % m;
      4'd1:  r = (ua + m - ub) % m;
      4'd2:  r = (ua * ub) % m;
      4'd3:  r = ua & ub;
      4'd4:  r = ua | ub;
      4'd5:  r = ua ^ ub;
      4'd6:  r = (~(ua ^ ub)) % m;
      4'd7:  r = (ub >= WIDTH) ? 0 : (ua * (longint'(1) << ub)) % m;
      4'd8:  r = (ub >= WIDTH) ? 0 : ua / (longint'(1) << ub);
      4'd9: begin
        sa = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
        if (ub >= WIDTH) q = (sa < 0) ? -1 : 0;
        else begin
          p2 = longint'(1) << ub;
          q = sa / p2;
          if (sa < 0 && (sa % p2) != 0) q = q - 1;
        end
        r = (q < 0) ? $unsigned(q + longint'(m)) : $unsigned(q);
      end
      4'd10: r = (ub == 0) ? m - 1 : ua / ub;
      4'd11: r = (ub == 0) ? ua : ua % ub;
      4'd12: r = (ua == m - 1) ? 1 : 0;
      4'd13: r = (ua != 0) ? 1 : 0;
      4'd14: begin
        for (int i = 0; i < WIDTH; i++) ones += int'(a[i]);
        r = ones % 2;
      end
      default: begin err = 1'b1; r = 0; end
    endcase
    return {err, r[WIDTH-1:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (acc[i]) begin req_valid[i] = 1'b0; acc[i] = 1'b0; end
    rsp_ready = (rdyMode == 2) ? ($urandom_range(0, 3) != 0) : (rdyMode == 1);
  endtask

  task automatic applyStimulus(input int id, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[id]             = 1'b1;
    req_op[4*id +: 4]         = op;
    req_a[WIDTH*id +: WIDTH]  = a;
    req_b[WIDTH*id +: WIDTH]  = b;
  endtask

  // Grant model: idle when nothing is outstanding, winner is first valid from the pointer.
  task automatic sampleGrant();
    logic [N-1:0]     exp;
    logic [WIDTH:0]   res;
    logic [3:0]       op;
    bit               found;
    int               w, idx;
    exp_t             e;
    #1;
    if (rst) return;
    exp = '0; found = 0;
    if (inflight == 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (!found && req_valid[idx]) begin exp[idx] = 1'b1; found = 1; end
      end
    end
    checkOutput(req_ready == exp, "grant", req_ready, exp);
    w = -1;
    for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) w = i;
    if (w >= 0) begin
      for (int i = 0; i < N; i++) if (i != w && req_valid[i]) waitCnt[i]++;
      checkOutput(waitCnt[w] <= N - 1, "fairness", waitCnt[w], N - 1);
      waitCnt[w] = 0;
      op     = req_op[4*w +: 4];
      res    = refModel(op, req_a[WIDTH*w +: WIDTH], req_b[WIDTH*w +: WIDTH]);
      e.id   = w;
      e.data = res[WIDTH-1:0];
      e.err  = res[WIDTH];
      e.lat  = (op == OP_DIV || op == OP_MOD) ? WIDTH + 1 : 2;
      e.tacc = cyc;
      sbq.push_back(e);
      mptr = (w + 1) % N;
      inflight++;
      acc[w] = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((inflight != 0 || req_valid != '0) && n < budget) begin
      tick();
      sampleGrant();
      n++;
    end
    checkOutput(inflight == 0 && req_valid == '0, "drain_timeout", inflight, 0);
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    tick();
    applyStimulus(id, op, a, b);
    sampleGrant();
    drain(200);
  endtask

  // Monitor: latency on rise, stability while stalled, payload on handshake.
  initial begin
    held = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin held = 0; continue; end
      if (rsp_valid) begin
        if (!held) begin
          checkOutput(sbq.size() != 0, "rsp_expected", sbq.size(), 1);
          if (sbq.size() != 0)
            checkOutput(cyc - sbq[0].tacc == sbq[0].lat, "latency", cyc - sbq[0].tacc, sbq[0].lat);
          heldVal  = {rsp_id, rsp_err, rsp_data};
          stableOk = 1;
          held     = 1;
        end else if ({rsp_id, rsp_err, rsp_data} != heldVal) stableOk = 0;
        if (rsp_ready) begin
          if (sbq.size() != 0) begin
            me = sbq.pop_front();
            checkOutput({rsp_id, rsp_err, rsp_data} == {IDW'(me.id), me.err, me.data}, "rsp",
                        {rsp_id, rsp_err, rsp_data}, {IDW'(me.id), me.err, me.data});
            checkOutput(stableOk, "rsp_stable", stableOk, 1);
            inflight--;
          end
          held = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin acc[i] = 1'b0; waitCnt[i] = 0; end
    repeat (3) @(negedge clk);
    #1;
    checkOutput(!rsp_valid && rsp_data == '0 && rsp_id == '0 && !rsp_err && req_ready == '0, "reset_state",
                {req_ready, rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    rst = 1'b0;

    $display("[TB] directed operations");
    rdyMode = 1;
    issue(0, OP_ADD, 8'd5, 8'd10);
    issue(0, OP_SUB, 8'd5, 8'd10);
    issue(1, OP_ASHR, 8'hFE, 8'd1);
    issue(0, OP_SHR, 8'hFE, 8'd9);
    issue(1, OP_SHL, 8'h9F, 8'd1);
    issue(0, OP_DIV, 8'd10, 8'd3);
    issue(1, OP_MOD, 8'd10, 8'd3);
    issue(0, OP_DIV, 8'd7, 8'd0);
    issue(1, OP_MOD, 8'd7, 8'd0);
    issue(0, OP_ILLEGAL, 8'h33, 8'h44);
    issue(1, OP_REDXOR, 8'h09, 8'd0);
    issue(0, OP_REDOR, 8'h00, 8'd0);
    issue(1, OP_REDAND, 8'hFF, 8'd0);
    issue(0, OP_ASHR, 8'h80, 8'd12);

    $display("[TB] fairness with both requesters busy");
    for (int r = 0; r < 12; r++) begin
      tick();
      for (int i = 0; i < N; i++) if (!req_valid[i]) applyStimulus(i, OP_ADD, WIDTH'(i), 8'd0);
      sampleGrant();
    end
    drain(200);

    $display("[TB] response stall");
    rdyMode = 0;
    tick();
    applyStimulus(0, OP_XOR, 8'h5A, 8'h0F);
    sampleGrant();
    tick();
    applyStimulus(1, OP_MUL, 8'd13, 8'd11);
    sampleGrant();
    for (int n = 0; n < 10 && !rsp_valid; n++) begin tick(); sampleGrant(); end
    checkOutput(rsp_valid, "stall_rsp_seen", rsp_valid, 1);
    repeat (5) begin tick(); sampleGrant(); end
    rdyMode = 1;
    drain(200);

    $display("[TB] reset during divide");
    tick();
    applyStimulus(0, OP_DIV, 8'd200, 8'd7);
    sampleGrant();
    repeat (2) begin tick(); sampleGrant(); end
    tick();
    rst = 1'b1;
    sbq.delete(); inflight = 0; mptr = 0; req_valid = '0;
    for (int i = 0; i < N; i++) begin acc[i] = 1'b0; waitCnt[i] = 0; end
    tick();
    rst = 1'b0;
    #1;
    checkOutput(!rsp_valid, "abort_no_rsp", rsp_valid, 0);
    tick();
    applyStimulus(0, OP_ADD, 8'd1, 8'd1);
    applyStimulus(1, OP_ADD, 8'd3, 8'd4);
    sampleGrant();
    drain(200);

    $display("[TB] randomized traffic");
    rdyMode = 2;
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          rop = 4'($urandom_range(0, 15));
          ra  = WIDTH'($urandom);
          case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = WIDTH'($urandom_range(0, WIDTH + 2));
            default: rb = WIDTH'($urandom);
          endcase
          applyStimulus(i, rop, ra, rb);
        end
      end
      sampleGrant();
    end
    rdyMode = 1;
    drain(300);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
